// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing the serial port byte-write interface (w_e/wr_data
// with the f_f full flag) among N_REQ byte producers. Each grant covers a burst
// of up to MAX_BURST bytes. Writes are registered one-cycle pulses spaced at
// least two clocks apart, so f_f always reflects the previous write before the
// next byte is accepted.
module serial_tx_arbiter #(
   parameter  int unsigned N_REQ     = 4,
   parameter  int unsigned WIDTH     = 8,
   parameter  int unsigned MAX_BURST = 4,
   localparam int unsigned GW        = $clog2(N_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     f_f,
   output logic                     w_e,
   output logic [WIDTH-1:0]         wr_data,
   output logic [GW-1:0]            grant_id,
   output logic                     busy
);

   localparam logic [3:0] MAXB = 4'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      GAP
   } state_t;

   state_t           state_q, state_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [GW-1:0]    rr_last_q, rr_last_d;
   logic [3:0]       burst_q, burst_d;
   logic             w_e_q, w_e_d;
   logic [WIDTH-1:0] wr_data_q, wr_data_d;

   logic             pick_found;
   logic [GW-1:0]    pick_idx;
   logic [GW-1:0]    cand;
   logic             valid_g;
   logic [WIDTH-1:0] data_g;
   logic             ready_g;
   logic             accept;

   // Round-robin search: first valid requester after rr_last, wrapping modulo N_REQ
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = GW'((32'(rr_last_q) + i) % N_REQ);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Select the valid bit and byte of the currently granted requester
   always_comb begin
      valid_g = 1'b0;
      data_g  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (GW'(i) == grant_q) begin
            valid_g = req_valid[i];
            data_g  = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // FSM next-state, write strobe generation and ready decode
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_last_d = rr_last_q;
      burst_d   = burst_q;
      w_e_d     = 1'b0;
      wr_data_d = wr_data_q;
      req_ready = '0;
      ready_g   = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               burst_d = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            // A write in flight blocks the next accept, giving the FIFO a
            // clock to update f_f before another byte is taken.
            ready_g = ~f_f & ~w_e_q;
            for (int unsigned i = 0; i < N_REQ; i++) begin
               req_ready[i] = ready_g && (GW'(i) == grant_q);
            end
            accept = valid_g & ready_g;
            if (accept) begin
               w_e_d     = 1'b1;
               wr_data_d = data_g;
               burst_d   = (burst_q < MAXB) ? burst_q + 4'd1 : burst_q;
            end
            if (accept && (burst_q + 4'd1 == MAXB)) begin
               state_d = GAP;
            end else if (!valid_g && !w_e_q) begin
               state_d = GAP;
            end
         end
         GAP: begin
            rr_last_d = grant_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_last_q <= GW'(N_REQ - 1);
         burst_q   <= '0;
         w_e_q     <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_last_q <= rr_last_d;
         burst_q   <= burst_d;
         w_e_q     <= w_e_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign w_e      = w_e_q;
   assign wr_data  = wr_data_q;
   assign grant_id = grant_q;
   assign busy     = (state_q == XFER) || (state_q == GAP);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: requester queues feed the DUT, a
// negedge monitor logs every FIFO write as {grant_id, wr_data}.
module tb_serial_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic        f_f = 1'b0;
   logic        w_e;
   logic [7:0]  wr_data;
   logic [1:0]  grant_id;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0] q [4][$];
   logic [3:0] hold = '0;
   logic [3:0] acc;

   logic [9:0] wr_log[$];
   int         wr_cyc[$];
   int         viol = 0;
   logic       ff_prev = 1'b0;

   serial_tx_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .f_f       (f_f),
      .w_e       (w_e),
      .wr_data   (wr_data),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Requester model: an accepted byte is popped after the edge that took it
   always begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
         req_valid[i]       = (q[i].size() > 0) && !hold[i];
         req_data[i*8 +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
      end
   end

   // FIFO-side monitor; ff_prev is f_f as seen by the accepting edge
   always @(negedge clk) begin
      if (w_e === 1'b1) begin
         wr_log.push_back({grant_id, wr_data});
         wr_cyc.push_back(cyc);
         if (ff_prev) viol++;
      end
      ff_prev = f_f;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] ent(input int g, input logic [7:0] d);
      return {g[1:0], d};
   endfunction

   task automatic do_reset();
      f_f  = 1'b0;
      hold = '0;
      for (int i = 0; i < 4; i++) q[i].delete();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      wr_log.delete();
      wr_cyc.delete();
      viol = 0;
   endtask

   task automatic wait_writes(input int n, input int budget, input string tag);
      int k = 0;
      while (wr_log.size() < n && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check(tag, 32'(wr_log.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((busy || q[0].size() > 0 || q[1].size() > 0 || q[2].size() > 0 ||
              q[3].size() > 0) && k < 400) begin
         @(negedge clk);
         #1;
         k++;
      end
      repeat (3) @(negedge clk);
      #1;
      check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int base;
      int we_seen;
      int rdy_seen;
      int lost;
      int k;
      int err;
      logic [7:0] e [4][$];

      // Reset values
      do_reset();
      check("rst_w_e", 32'(w_e), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // 1: single requester, three bytes, alternate-cycle strobes
      q[2].push_back(8'hA1);
      q[2].push_back(8'hA2);
      q[2].push_back(8'hA3);
      wait_writes(3, 60, "t1_wait");
      check("t1_wr0", 32'(wr_log[0]), 32'(ent(2, 8'hA1)));
      check("t1_wr1", 32'(wr_log[1]), 32'(ent(2, 8'hA2)));
      check("t1_wr2", 32'(wr_log[2]), 32'(ent(2, 8'hA3)));
      check("t1_gap01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);
      check("t1_gap12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd2);
      wait_idle("t1_idle");
      check("t1_grant_kept", 32'(grant_id), 32'd2);
      // rr_last is now 2, so 3 beats 0 when both arrive together
      q[0].push_back(8'h0B);
      q[3].push_back(8'h3B);
      wait_writes(5, 60, "t1_rr_wait");
      check("t1_rr_first", 32'(wr_log[3]), 32'(ent(3, 8'h3B)));
      check("t1_rr_second", 32'(wr_log[4]), 32'(ent(0, 8'h0B)));
      wait_idle("t1_rr_idle");

      // 2: all four requesters continuously valid, bursts of four
      do_reset();
      for (int i = 0; i < 4; i++)
         for (int s = 0; s < 8; s++) q[i].push_back(8'(i * 64 + s));
      wait_writes(32, 600, "t2_wait");
      for (int g = 0; g < 5; g++)
         for (int j = 0; j < 4; j++)
            check($sformatf("t2_wr%0d", g * 4 + j), 32'(wr_log[g * 4 + j]),
                  32'(ent(g % 4, 8'((g % 4) * 64 + (g / 4) * 4 + j))));
      wait_idle("t2_idle");
      check("t2_total", 32'(wr_log.size()), 32'd32);
      check("t2_ff_viol", 32'(viol), 32'd0);

      // 3: FIFO full stalls the grant for ten cycles
      do_reset();
      q[1].push_back(8'h51);
      q[1].push_back(8'h52);
      q[1].push_back(8'h53);
      wait_writes(1, 40, "t3_first");
      @(posedge clk);
      #1;
      f_f = 1'b1;
      we_seen = 0; rdy_seen = 0; lost = 0;
      repeat (10) begin
         @(negedge clk);
         #1;
         if (w_e) we_seen++;
         if (req_ready != 4'b0000) rdy_seen++;
         if (grant_id != 2'd1 || !busy) lost++;
      end
      check("t3_stall_we", 32'(we_seen), 32'd0);
      check("t3_stall_ready", 32'(rdy_seen), 32'd0);
      check("t3_grant_held", 32'(lost), 32'd0);
      check("t3_stall_count", 32'(wr_log.size()), 32'd1);
      @(posedge clk);
      #1;
      f_f = 1'b0;
      wait_writes(3, 40, "t3_resume");
      check("t3_wr1", 32'(wr_log[1]), 32'(ent(1, 8'h52)));
      check("t3_wr2", 32'(wr_log[2]), 32'(ent(1, 8'h53)));
      wait_idle("t3_idle");

      // 4: reset mid-burst, then requester 0 wins
      do_reset();
      for (int s = 1; s <= 4; s++) q[2].push_back(8'(8'h20 + s));
      wait_writes(2, 40, "t4_two");
      q[0].push_back(8'h01);
      rst_n = 1'b0;
      #1;
      check("t4_rst_we", 32'(w_e), 32'd0);
      check("t4_rst_busy", 32'(busy), 32'd0);
      check("t4_rst_ready", 32'(req_ready), 32'd0);
      base = wr_log.size();
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      check("t4_no_wr_in_reset", 32'(wr_log.size()), 32'(base));
      wait_writes(base + 2, 80, "t4_after");
      check("t4_first_after", 32'(wr_log[base]), 32'(ent(0, 8'h01)));
      check("t4_resumed_2", 32'(wr_log[base + 1]), 32'(ent(2, 8'h23)));
      wait_idle("t4_idle");

      // 5: granted requester drops valid after one byte
      do_reset();
      q[3].push_back(8'h31);
      q[3].push_back(8'h32);
      k = 0;
      while (!(busy && grant_id == 2'd3) && k < 20) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("t5_grant3", 32'(grant_id), 32'd3);
      q[0].push_back(8'h0D);
      wait_writes(1, 40, "t5_first");
      q[3].delete();
      wait_writes(2, 40, "t5_second");
      wait_idle("t5_idle");
      check("t5_count", 32'(wr_log.size()), 32'd2);
      check("t5_wr0", 32'(wr_log[0]), 32'(ent(3, 8'h31)));
      check("t5_wr1", 32'(wr_log[1]), 32'(ent(0, 8'h0D)));

      // 6: random traffic with random full flag and valid gaps
      do_reset();
      for (int i = 0; i < 4; i++)
         for (int s = 0; s < 16; s++) begin
            logic [7:0] b;
            b = 8'($urandom);
            q[i].push_back(b);
            e[i].push_back(b);
         end
      k = 0;
      while (wr_log.size() < 64 && k < 3000) begin
         @(posedge clk);
         #1;
         f_f  = ($urandom_range(0, 9) < 3);
         hold = 4'($urandom) & 4'($urandom);
         k++;
      end
      @(posedge clk);
      #1;
      f_f  = 1'b0;
      hold = '0;
      wait_idle("t6_idle");
      check("t6_total", 32'(wr_log.size()), 32'd64);
      err = 0;
      foreach (wr_log[n]) begin
         int g;
         g = int'(wr_log[n][9:8]);
         if (e[g].size() == 0) err++;
         else if (e[g].pop_front() !== wr_log[n][7:0]) err++;
      end
      check("t6_order_errs", 32'(err), 32'd0);
      check("t6_ff_viol", 32'(viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
